rom_read_arbiter: RTL

Shares one read port of the 512x32 instruction/data ROM between two requesters (port 0: instruction fetch, port 1: data load) using a round-robin req/valid handshake. It drives the ROM port's enable and address from registers and captures the ROM output one cycle after issue. It returns the word to the granted requester with a single-cycle valid pulse. Each ROM port (a/b) gets its own instance; all instances sit in the memory subsystem between the CPU front end and the ROM.

---
 rtl/rom_read_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one ROM read port between instruction fetch (port 0)
// and data load (port 1); back-to-back issue gives one word per cycle under contention.
module rom_read_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              valid0,
    output logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              valid1,
    output logic [DATA_W-1:0] data1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_do,
    output logic              busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state;
    logic   gnt;
    logic   last;
    logic   pick;
    logic   other_req;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign pick      = (req0 && req1) ? ~last : req1;
    assign other_req = gnt ? req0 : req1;
    assign busy      = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            gnt      <= 1'b0;
            last     <= 1'b1;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            data0    <= '0;
            data1    <= '0;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        rom_en   <= 1'b1;
                        rom_addr <= pick ? addr1 : addr0;
                        gnt      <= pick;
                        state    <= BUSY;
                    end else begin
                        rom_en <= 1'b0;
                    end
                end
                BUSY: begin
                    if (gnt) begin
                        valid1 <= 1'b1;
                        data1  <= rom_do;
                    end else begin
                        valid0 <= 1'b1;
                        data0  <= rom_do;
                    end
                    last <= gnt;
                    // The served port's req is still high here, so only the other port may chain.
                    if (other_req) begin
                        rom_en   <= 1'b1;
                        rom_addr <= gnt ? addr0 : addr1;
                        gnt      <= ~gnt;
                    end else begin
                        rom_en <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
